// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: sequencer states and error codes.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        PL_IDLE    = 3'd0,
        PL_LOAD    = 3'd1,
        PL_RELEASE = 3'd2,
        PL_RUN     = 3'd3,
        PL_DONE    = 3'd4
    } pl_state_t;

    localparam logic [1:0] PL_ERR_NONE = 2'b00;
    localparam logic [1:0] PL_ERR_OVF  = 2'b01;
    localparam logic [1:0] PL_ERR_TMO  = 2'b10;

endpackage

// File: rtl/prog_loader_sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader / run sequencer: streams an image into instruction memory, releases
// the core, counts run cycles. Define PROG_LOADER_TIMEOUT_EN to enable the RUN watchdog.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          D   = 12,
    parameter int          W   = 9,
    parameter int          CW  = 16,
    parameter int unsigned TMO = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [W-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          imem_we,
    output logic [D-1:0]  imem_addr,
    output logic [W-1:0]  imem_wdata,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic [CW-1:0] cycles,
    output logic [1:0]    err
);

    pl_state_t    state, state_nxt;
    logic         rel_phase;
    logic [D-1:0] ptr;
    logic [1:0]   err_q, err_nxt;
    logic         go, xfer, ptr_last, cnt_en, tmo_hit;

    assign go       = start && ((state == PL_IDLE) || (state == PL_DONE));
    assign ld_ready = (state == PL_LOAD);
    assign xfer     = ld_ready && ld_valid;
    assign ptr_last = (ptr == {D{1'b1}});

`ifdef PROG_LOADER_TIMEOUT_EN
    assign tmo_hit = (cycles == CW'(TMO));
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        cnt_en    = 1'b0;
        case (state)
            PL_IDLE, PL_DONE: begin
                if (go) begin
                    state_nxt = PL_LOAD;
                    err_nxt   = PL_ERR_NONE;
                end
            end
            PL_LOAD: begin
                if (xfer) begin
                    if (ld_last) begin
                        state_nxt = PL_RELEASE;
                    end else if (ptr_last) begin
                        state_nxt = PL_DONE;
                        err_nxt   = PL_ERR_OVF;
                    end
                end
            end
            PL_RELEASE: begin
                if (rel_phase) state_nxt = PL_RUN;
            end
            PL_RUN: begin
                // done has priority so its own cycle is never counted
                if (core_done) begin
                    state_nxt = PL_DONE;
                end else if (tmo_hit) begin
                    state_nxt = PL_DONE;
                    err_nxt   = PL_ERR_TMO;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_nxt = PL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PL_IDLE;
            rel_phase  <= 1'b0;
            ptr        <= '0;
            err_q      <= PL_ERR_NONE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            err_q     <= err_nxt;
            rel_phase <= (state == PL_RELEASE) && !rel_phase;
            imem_we   <= xfer;
            if (go) begin
                ptr <= '0;
            end else if (xfer) begin
                ptr <= ptr + D'(1);
            end
            if (xfer) begin
                imem_addr  <= ptr;
                imem_wdata <= ld_data;
            end
        end
    end

    sat_counter #(.WIDTH(CW)) u_cycles (
        .clk   (clk),
        .rst_n (reset),
        .clr   (go),
        .en    (cnt_en),
        .count (cycles)
    );

    // Core stays in reset through loading and the first release cycle.
    assign core_reset = (state == PL_IDLE) || (state == PL_LOAD) ||
                        ((state == PL_RELEASE) && !rel_phase);
    assign core_req   = (state == PL_RELEASE) && rel_phase;
    assign busy       = (state == PL_LOAD) || (state == PL_RELEASE) || (state == PL_RUN);
    assign finished   = (state == PL_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a cycle-level behavioural model.
module tb_prog_loader;

    localparam int D     = 3;
    localparam int W     = 9;
    localparam int CW    = 5;
    localparam int TMO   = 20;
    localparam int DEPTH = 1 << D;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef PROG_LOADER_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    localparam int P_IDLE = 0, P_LOAD = 1, P_REL_A = 2, P_REL_B = 3, P_RUN = 4, P_DONE = 5;

    bit            clk = 1'b0;
    logic          reset, start, ld_valid, ld_last, core_done;
    logic [W-1:0]  ld_data;
    logic          ld_ready, imem_we, core_reset, core_req, busy, finished;
    logic [D-1:0]  imem_addr;
    logic [W-1:0]  imem_wdata;
    logic [CW-1:0] cycles;
    logic [1:0]    err;

    int n_chk = 0, n_pass = 0;
    bit chk_en = 1'b0;
    int mp, m_ptr, m_cycles, m_err, m_addr, m_wdata;
    bit m_we;
    int wlog_addr[$], wlog_data[$];
    int req_count;

    always #5 clk = ~clk;

    prog_loader #(.D(D), .W(W), .CW(CW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset), .core_req(core_req),
        .core_done(core_done), .busy(busy), .finished(finished), .cycles(cycles), .err(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mp = P_IDLE; m_ptr = 0; m_cycles = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_we = 1'b0;
    endtask

    // One clock edge of the behavioural model, using the inputs present at that edge.
    task automatic model_step();
        m_we = 1'b0;
        case (mp)
            P_IDLE, P_DONE: if (start) begin
                mp = P_LOAD; m_cycles = 0; m_err = 0; m_ptr = 0;
            end
            P_LOAD: if (ld_valid) begin
                m_we = 1'b1; m_addr = m_ptr; m_wdata = int'(ld_data);
                if (ld_last) mp = P_REL_A;
                else if (m_ptr == DEPTH - 1) begin m_err = 1; mp = P_DONE; end
                m_ptr = (m_ptr + 1) % DEPTH;
            end
            P_REL_A: mp = P_REL_B;
            P_REL_B: mp = P_RUN;
            P_RUN: begin
                if (core_done) mp = P_DONE;
                else if (TMO_ON && m_cycles >= TMO) begin m_err = 2; mp = P_DONE; end
                else if (m_cycles < CMAX) m_cycles++;
            end
            default: mp = P_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ld_ready",   int'(ld_ready),   int'(mp == P_LOAD));
            chk("imem_we",    int'(imem_we),    int'(m_we));
            chk("imem_addr",  int'(imem_addr),  m_addr);
            chk("imem_wdata", int'(imem_wdata), m_wdata);
            chk("core_reset", int'(core_reset), int'(mp == P_IDLE || mp == P_LOAD || mp == P_REL_A));
            chk("core_req",   int'(core_req),   int'(mp == P_REL_B));
            chk("busy",       int'(busy),       int'(mp >= P_LOAD && mp <= P_RUN));
            chk("finished",   int'(finished),   int'(mp == P_DONE));
            chk("cycles",     int'(cycles),     m_cycles);
            chk("err",        int'(err),        m_err);
        end
        if (imem_we) begin
            wlog_addr.push_back(int'(imem_addr));
            wlog_data.push_back(int'(imem_wdata));
        end
        if (core_req) req_count++;
    end

    task automatic step(input bit s, input bit v, input int d, input bit l, input bit cd);
        start = s; ld_valid = v; ld_data = W'(d); ld_last = l; core_done = cd;
        @(posedge clk);
        #1;
        if (reset) model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic clear_logs();
        wlog_addr.delete(); wlog_data.delete(); req_count = 0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        core_done = 1'b0; ld_data = '0;
        model_reset();
        chk_en = 1'b1;
        #1;
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_ld_ready", int'(ld_ready), 0);
        chk("rst_cycles", int'(cycles), 0);
        idle(2);
        reset = 1'b1;
        idle(1);

        // Three-word image, then a 10-cycle run.
        clear_logs();
        step(1, 0, 0, 0, 0);
        chk("load_ready", int'(ld_ready), 1);
        step(0, 1, 'h1A5, 0, 0);
        step(0, 1, 'h0FF, 0, 0);
        step(0, 1, 'h100, 1, 0);
        chk("req_not_yet", int'(core_req), 0);
        chk("ready_dropped", int'(ld_ready), 0);
        idle(1);
        chk("req_latency", int'(core_req), 1);
        chk("w3_count", wlog_addr.size(), 3);
        if (wlog_addr.size() == 3) begin
            chk("w0_addr", wlog_addr[0], 0); chk("w0_data", wlog_data[0], 'h1A5);
            chk("w1_addr", wlog_addr[1], 1); chk("w1_data", wlog_data[1], 'h0FF);
            chk("w2_addr", wlog_addr[2], 2); chk("w2_data", wlog_data[2], 'h100);
        end
        idle(1);
        repeat (10) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("run_finished", int'(finished), 1);
        chk("run_cycles", int'(cycles), 10);
        chk("run_err", int'(err), 0);
        step(1, 0, 0, 0, 0);
        chk("reload_cycles", int'(cycles), 0);
        chk("reload_ready", int'(ld_ready), 1);

        // Valid toggling: only transfers are written, addresses contiguous.
        clear_logs();
        for (int i = 0; i < 8; i++)
            step(0, (i % 2) == 0, $urandom_range(0, 511), i == 6, 0);
        chk("toggle_count", wlog_addr.size(), 4);
        for (int i = 0; i < wlog_addr.size(); i++) chk("toggle_addr", wlog_addr[i], i);
        // done already high on RUN entry
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("early_done_fin", int'(finished), 1);
        chk("early_done_cycles", int'(cycles), 0);

        // Overflow: nine words, no last.
        clear_logs();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, $urandom_range(0, 511), 0, 0);
        idle(3);
        chk("ovf_err", int'(err), 1);
        chk("ovf_finished", int'(finished), 1);
        chk("ovf_writes", wlog_addr.size(), 8);
        if (wlog_addr.size() == 8) chk("ovf_last_addr", wlog_addr[7], 7);
        chk("ovf_no_req", req_count, 0);

        // Watchdog / saturation with done held low.
        step(1, 0, 0, 0, 0);
        step(0, 1, 'h055, 1, 0);
        idle(2);
        idle(40);
`ifdef PROG_LOADER_TIMEOUT_EN
        chk("tmo_err", int'(err), 2);
        chk("tmo_finished", int'(finished), 1);
        chk("tmo_cycles", int'(cycles), 20);
        chk("tmo_core_reset", int'(core_reset), 0);
`else
        chk("notmo_busy", int'(busy), 1);
        chk("notmo_err", int'(err), 0);
        chk("sat_cycles", int'(cycles), CMAX);
        step(0, 0, 0, 0, 1);
        chk("notmo_finished", int'(finished), 1);
`endif

        // Reset during RUN, then a clean load.
        step(1, 0, 0, 0, 0);
        step(0, 1, 'h011, 0, 0);
        step(0, 1, 'h022, 1, 0);
        idle(2);
        idle(5);
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_core_reset", int'(core_reset), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cycles", int'(cycles), 0);
        chk("mid_rst_we", int'(imem_we), 0);
        chk("mid_rst_addr", int'(imem_addr), 0);
        idle(2);
        reset = 1'b1;
        idle(2);
        clear_logs();
        step(1, 0, 0, 0, 0);
        step(0, 1, 'h1C3, 1, 0);
        idle(1);
        chk("post_rst_writes", wlog_addr.size(), 1);
        if (wlog_addr.size() == 1) chk("post_rst_addr0", wlog_addr[0], 0);

        // Random traffic against the model.
        repeat (3000)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 511), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Front-end run sequencer upstream of the processor top level. Accepts a program image as a stream of 9-bit machine words over a valid/ready handshake and writes it into the instruction ROM's write port. Holds the core in reset while loading, releases it, pulses `req`, and then counts cycles until the core raises `done`. It reports completion, the cycle count and error status to the host.

## Interface
- `D`, 12, instruction address width; matches the core PC width.
- `W`, 9, instruction word width.
- `CW`, 16, cycle counter width.
- `TMO`, 16'hFFFF, watchdog limit in cycles; used only with `PROG_LOADER_TIMEOUT_EN`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  host request to begin a load; sampled only in IDLE or DONE.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  W  machine word.
- `ld_last`  in  1  marks the final word of the image.
- `ld_ready`  out  1  loader may transfer.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  D  write address.
- `imem_wdata`  out  W  write data.
- `core_reset`  out  1  active-high reset to the core.
- `core_req`  out  1  one-cycle start pulse to the core.
- `core_done`  in  1  core completion.
- `busy`  out  1  high in LOAD, RELEASE and RUN.
- `finished`  out  1  high in DONE.
- `cycles`  out  CW  RUN cycle count, saturating.
- `err`  out  2  00 none, 01 overflow, 10 timeout.

## Operation
- States: IDLE, LOAD, RELEASE, RUN, DONE.
- IDLE: `core_reset` = 1 and `ld_ready` = 0. When `start` = 1, go to LOAD, clear `cycles` and `err`, and set the write pointer to 0.
- LOAD: `ld_ready` = 1. A transfer occurs when `ld_valid` and `ld_ready` are both high in the same cycle. On a transfer, the word and pointer are registered and the pointer increments.
  - A transfer with `ld_last` = 1 goes to RELEASE.
  - A transfer without `ld_last` while the pointer = 2^D-1 sets `err` = 01 and goes to DONE without starting the core. The final word is still written.
- RELEASE: `core_reset` = 1 in the first cycle and 0 in the second, with `core_req` = 1 in that second cycle. Then go to RUN.
- RUN: `core_reset` = 0. `cycles` increments every cycle and saturates at 2^CW-1. When `core_done` = 1, go to DONE; the cycle in which `core_done` is seen is not counted.
- DONE: `finished` = 1 and `core_reset` = 0, so the core state remains readable. `start` = 1 re-enters LOAD with the same clears as from IDLE.
- `start` outside IDLE/DONE is ignored.
- A `core_done` already high on RUN entry completes immediately, with `cycles` = 0.

## Timing
- Reset values: state IDLE, `ld_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `core_reset` 1, `core_req` 0, `busy` 0, `finished` 0, `cycles` 0, `err` 00.
- `imem_we`, `imem_addr` and `imem_wdata` are registered. A word accepted at edge N is written at edge N+1.
- `ld_ready` is registered from the state. It deasserts in the cycle after the `ld_last` transfer, so no further transfer is accepted.
- Latency from the `ld_last` transfer to `core_req` is 2 cycles.
- `core_done` is sampled each RUN cycle. `finished` rises 1 cycle after `core_done` is sampled.
- Reset asserted mid-operation returns the block to IDLE immediately and holds the core in reset. Partially written memory is not cleared.

## Configuration
- `PROG_LOADER_TIMEOUT_EN` defined: in RUN, when `cycles` reaches `TMO` without `core_done`, set `err` = 10 and go to DONE, leaving `core_reset` at 0.
- Undefined: no watchdog, `err` = 10 never occurs, and `TMO` is unused.

## Structure
- Shared package `prog_loader_pkg`:
  - state enum `pl_state_t`;
  - error codes `PL_ERR_NONE`, `PL_ERR_OVF`, `PL_ERR_TMO`.
- One sub-module, `sat_counter`, parameterised by width, with clear and enable inputs. It is used for `cycles`.
- Everything else is a single FSM plus datapath registers.

## Test plan
- Load 3 words (0x1A5, 0x0FF, 0x100, `ld_last` on the third):
  - `imem_we` pulses write addresses 0, 1, 2 with those words;
  - `core_req` pulses 2 cycles after the third transfer.
- `ld_valid` toggled every other cycle during load: only transfers are written, and addresses stay contiguous.
- `core_done` raised 10 cycles after `core_req`: `cycles` = 10, `finished` = 1, `err` = 00; then `start` reloads with `cycles` cleared.
- D=3, load 9 words with no `ld_last`: `err` = 01 after the 8th transfer and `core_req` never pulses.
- With `PROG_LOADER_TIMEOUT_EN`, `TMO` = 20 and `core_done` held low: DONE is entered with `err` = 10 and `cycles` = 20. Without the macro, the block stays in RUN.
- Reset pulsed low during RUN: `core_reset` = 1 immediately, all outputs return to their reset values, and `start` 2 cycles later begins a clean load at address 0.
